// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates the fetcher and the load/store buffer
// onto the 8-bit RAM port and assembles little-endian 32-bit results.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_ready,
  input  logic [31:0] if_addr,
  output logic        to_if_ok,
  output logic [31:0] to_if_data,
  input  logic        lsb_ready,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        to_lsb_ok,
  output logic [31:0] to_lsb_data,
  input  logic        rob_clear,
  output logic [1:0]  dbg_state
);

  // Requests are level-held by the requesters: a request is taken in IDLE and
  // acknowledged by a one-cycle ok pulse in DONE, after which ready drops.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state;
  logic        owner_lsb;
  logic [2:0]  n_bytes;
  logic [2:0]  cnt;
  logic [31:0] wdata;
  logic [31:0] rdata;

  logic        lsb_io_block;
  logic        take_lsb;
  logic [2:0]  lsb_n;
  logic [4:0]  cap_sh;
  logic [4:0]  wr_sh;
  logic [31:0] rd_next;
  logic [31:0] wr_shifted;

  assign dbg_state = state;

  // Stores into the IO window wait for UART space; the fetcher may slip past.
  assign lsb_io_block = lsb_wr && (lsb_addr[17:16] == 2'b11) && io_buffer_full;
  assign take_lsb     = lsb_ready && !lsb_io_block;

  always_comb begin
    case (lsb_len)
      2'd0:    lsb_n = 3'd1;
      2'd1:    lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
  end

  // In READ, cnt counts cycles spent there; mem_din carries byte cnt-1.
  assign cap_sh     = {cnt[1:0] - 2'd1, 3'b000};
  assign rd_next    = rdata | ({24'd0, mem_din} << cap_sh);
  assign wr_sh      = {cnt[1:0] + 2'd1, 3'b000};
  assign wr_shifted = wdata >> wr_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner_lsb   <= 1'b0;
      n_bytes     <= 3'd0;
      cnt         <= 3'd0;
      wdata       <= 32'd0;
      rdata       <= 32'd0;
      mem_a       <= 32'd0;
      mem_dout    <= 8'd0;
      mem_wr      <= 1'b0;
      to_if_ok    <= 1'b0;
      to_if_data  <= 32'd0;
      to_lsb_ok   <= 1'b0;
      to_lsb_data <= 32'd0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          to_if_ok  <= 1'b0;
          to_lsb_ok <= 1'b0;
          mem_wr    <= 1'b0;
          if (rob_clear) begin
            state <= S_IDLE;
          end else if (take_lsb) begin
            owner_lsb <= 1'b1;
            mem_a     <= lsb_addr;
            n_bytes   <= lsb_n;
            wdata     <= lsb_wdata;
            cnt       <= 3'd0;
            rdata     <= 32'd0;
            if (lsb_wr) begin
              mem_wr   <= 1'b1;
              mem_dout <= lsb_wdata[7:0];
              state    <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end else if (if_ready) begin
            owner_lsb <= 1'b0;
            mem_a     <= if_addr;
            n_bytes   <= 3'd4;
            cnt       <= 3'd0;
            rdata     <= 32'd0;
            state     <= S_READ;
          end
        end

        S_READ: begin
          if (rob_clear) begin
            state  <= S_IDLE;
            mem_wr <= 1'b0;
            rdata  <= 32'd0;
          end else begin
            if (cnt != 3'd0) rdata <= rd_next;
            if (cnt == n_bytes) begin
              state <= S_DONE;
              if (owner_lsb) begin
                to_lsb_ok   <= 1'b1;
                to_lsb_data <= rd_next;
              end else begin
                to_if_ok   <= 1'b1;
                to_if_data <= rd_next;
              end
            end else begin
              cnt <= cnt + 3'd1;
              if ((cnt + 3'd1) < n_bytes) mem_a <= mem_a + 32'd1;
            end
          end
        end

        // A store that has started is already committed, so rollback cannot stop it.
        S_WRITE: begin
          if (cnt == (n_bytes - 3'd1)) begin
            mem_wr    <= 1'b0;
            to_lsb_ok <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt      <= cnt + 3'd1;
            mem_a    <= mem_a + 32'd1;
            mem_dout <= wr_shifted[7:0];
          end
        end

        S_DONE: begin
          to_if_ok  <= 1'b0;
          to_lsb_ok <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a transaction-level model expands each accepted request
// into its per-cycle bus/ok expectations, checked every cycle, plus directed cases.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_ready;
  logic [31:0] if_addr;
  logic        to_if_ok;
  logic [31:0] to_if_data;
  logic        lsb_ready, lsb_wr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr, lsb_wdata;
  logic        to_lsb_ok;
  logic [31:0] to_lsb_data;
  logic        rob_clear;
  logic [1:0]  dbg_state;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_ready(if_ready), .if_addr(if_addr), .to_if_ok(to_if_ok), .to_if_data(to_if_data),
    .lsb_ready(lsb_ready), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .to_lsb_ok(to_lsb_ok), .to_lsb_data(to_lsb_data),
    .rob_clear(rob_clear), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- memories ----------------
  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  // RAM device: one-cycle read latency, part of the rdy-gated system.
  initial begin
    mem_din = 8'd0;
    forever begin
      @(posedge clk);
      if (rdy) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram_rd(mem_a);
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          chk_a;
    logic [31:0] a;
    bit          chk_d;
    logic [7:0]  d;
    bit          wr;
    bit          if_ok;
    bit          lsb_ok;
    bit          chk_data;
    bit          rd_phase;
  } exp_t;

  exp_t        plan_q[$];   // front = expectation for the current cycle; empty = idle
  logic [31:0] exp_q[$];    // expected assembled read data, one per pending read

  function automatic exp_t blank();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  task automatic plan_txn(input bit is_lsb, input bit is_wr, input logic [31:0] base,
                          input int n, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] data;
    data = 32'd0;
    for (int i = 0; i < n; i++) begin
      e = blank();
      e.chk_a = 1'b1;
      e.a     = base + 32'(i);
      if (is_wr) begin
        e.chk_d = 1'b1;
        e.d     = wd[8*i +: 8];
        e.wr    = 1'b1;
        ref_mem[base + 32'(i)] = wd[8*i +: 8];
      end else begin
        e.rd_phase = 1'b1;
        data = data | (32'(ref_rd(base + 32'(i))) << (8*i));
      end
      plan_q.push_back(e);
    end
    if (!is_wr) begin
      e = blank();
      e.rd_phase = 1'b1;
      plan_q.push_back(e);
      exp_q.push_back(data);
    end
    e = blank();
    e.if_ok    = !is_lsb;
    e.lsb_ok   = is_lsb;
    e.chk_data = !is_wr;
    plan_q.push_back(e);
  endtask

  initial begin
    exp_t cur;
    forever begin
      @(posedge clk);
      if (rst) begin
        plan_q.delete();
        exp_q.delete();
      end else if (rdy) begin
        if (plan_q.size() != 0) begin
          cur = plan_q.pop_front();
          if (cur.rd_phase && rob_clear) begin
            plan_q.delete();
            exp_q.delete();
          end else if (cur.chk_data) begin
            void'(exp_q.pop_front());
          end
        end else if (!rob_clear) begin
          if (lsb_ready && !(lsb_wr && lsb_addr[17:16] == 2'b11 && io_buffer_full))
            plan_txn(1'b1, lsb_wr, lsb_addr,
                     (lsb_len == 2'd0) ? 1 : (lsb_len == 2'd1) ? 2 : 4, lsb_wdata);
          else if (if_ready)
            plan_txn(1'b0, 1'b0, if_addr, 4, 32'd0);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e = (plan_q.size() != 0) ? plan_q[0] : blank();
        chk("cmp_mem_wr", 32'(mem_wr), 32'(e.wr));
        chk("cmp_if_ok", 32'(to_if_ok), 32'(e.if_ok));
        chk("cmp_lsb_ok", 32'(to_lsb_ok), 32'(e.lsb_ok));
        if (e.chk_a) chk("cmp_mem_a", mem_a, e.a);
        if (e.chk_d) chk("cmp_mem_dout", 32'(mem_dout), 32'(e.d));
        if (e.chk_data && e.if_ok) chk("cmp_if_data", to_if_data, exp_q[0]);
        if (e.chk_data && e.lsb_ok) chk("cmp_lsb_data", to_lsb_data, exp_q[0]);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic req_if(input logic [31:0] a);
    if_ready = 1'b1;
    if_addr  = a;
  endtask

  task automatic req_lsb(input bit w, input logic [1:0] len, input logic [31:0] a,
                         input logic [31:0] wd);
    lsb_ready = 1'b1;
    lsb_wr    = w;
    lsb_len   = len;
    lsb_addr  = a;
    lsb_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h0003_0000 | 32'($urandom_range(0, 255));
      1:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      default: return 32'($urandom_range(0, 1023));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int pend;
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; rob_clear = 1'b0;
    if_ready = 1'b0; if_addr = 32'd0;
    lsb_ready = 1'b0; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    preload(32'h104, 8'h93); preload(32'h105, 8'h00);
    preload(32'h106, 8'h10); preload(32'h107, 8'h00);
    preload(32'h7, 8'hA5);

    repeat (3) tick();
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_if_ok", 32'(to_if_ok), 32'd0);
    chk("rst_lsb_ok", 32'(to_lsb_ok), 32'd0);
    chk("rst_if_data", to_if_data, 32'd0);
    chk("rst_lsb_data", to_lsb_data, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();

    // word fetch at 0x100
    req_if(32'h100);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 4) chk("fetch_addr", mem_a, 32'h100 + 32'(k - 1));
      if (k < 6) chk("fetch_early_ok", 32'(to_if_ok), 32'd0);
    end
    chk("fetch_ok", 32'(to_if_ok), 32'd1);
    chk("fetch_data", to_if_data, 32'h0000_0513);
    if_ready = 1'b0;
    tick();
    chk("fetch_ok_width", 32'(to_if_ok), 32'd0);
    tick();

    // LSB byte load beats a simultaneous fetch
    req_if(32'h104);
    req_lsb(1'b0, 2'd0, 32'h7, 32'd0);
    tick();
    chk("arb_addr", mem_a, 32'h7);
    repeat (2) tick();
    chk("arb_lsb_ok", 32'(to_lsb_ok), 32'd1);
    chk("arb_lsb_data", to_lsb_data, 32'h0000_00A5);
    chk("arb_if_wait", 32'(to_if_ok), 32'd0);
    lsb_ready = 1'b0;
    repeat (7) tick();
    chk("arb_if_ok", 32'(to_if_ok), 32'd1);
    chk("arb_if_data", to_if_data, 32'h0010_0093);
    if_ready = 1'b0;
    settle();

    // half store 0xBEEF to 0x200
    req_lsb(1'b1, 2'd1, 32'h200, 32'h1234_BEEF);
    tick();
    chk("hs_a0", mem_a, 32'h200);
    chk("hs_d0", 32'(mem_dout), 32'hEF);
    chk("hs_wr0", 32'(mem_wr), 32'd1);
    tick();
    chk("hs_a1", mem_a, 32'h201);
    chk("hs_d1", 32'(mem_dout), 32'hBE);
    tick();
    chk("hs_ok", 32'(to_lsb_ok), 32'd1);
    chk("hs_wr_end", 32'(mem_wr), 32'd0);
    lsb_ready = 1'b0;
    tick();
    chk("hs_ram0", 32'(ram_rd(32'h200)), 32'hEF);
    chk("hs_ram1", 32'(ram_rd(32'h201)), 32'hBE);
    tick();

    // IO stall: blocked store, fetch served meanwhile
    io_buffer_full = 1'b1;
    req_lsb(1'b1, 2'd2, 32'h0003_0000, 32'hCAFE_F00D);
    req_if(32'h100);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("io_no_wr", 32'(mem_wr), 32'd0);
      if (k == 6) begin
        chk("io_if_ok", 32'(to_if_ok), 32'd1);
        chk("io_if_data", to_if_data, 32'h0000_0513);
        if_ready = 1'b0;
      end
    end
    io_buffer_full = 1'b0;
    tick();
    chk("io_wr_start", 32'(mem_wr), 32'd1);
    chk("io_wr_addr", mem_a, 32'h0003_0000);
    chk("io_wr_byte", 32'(mem_dout), 32'h0D);
    repeat (4) tick();
    chk("io_st_ok", 32'(to_lsb_ok), 32'd1);
    lsb_ready = 1'b0;
    settle();

    // rollback during fetch cycle 3
    req_if(32'h100);
    repeat (3) tick();
    rob_clear = 1'b1;
    if_ready  = 1'b0;
    tick();
    rob_clear = 1'b0;
    chk("rb_idle", 32'(dbg_state), 32'd0);
    chk("rb_wr", 32'(mem_wr), 32'd0);
    for (int k = 4; k <= 8; k++) begin
      chk("rb_no_ok", 32'(to_if_ok), 32'd0);
      tick();
    end

    // rollback during store cycle 2 is ignored
    req_lsb(1'b1, 2'd2, 32'h204, 32'h1122_3344);
    repeat (2) tick();
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    tick();
    chk("rbs_wr4", 32'(mem_wr), 32'd1);
    chk("rbs_byte4", 32'(mem_dout), 32'h11);
    tick();
    chk("rbs_ok", 32'(to_lsb_ok), 32'd1);
    lsb_ready = 1'b0;
    settle();

    // reset mid-read
    req_if(32'h100);
    repeat (3) tick();
    rst = 1'b1;
    if_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("mrst_mem_a", mem_a, 32'd0);
    chk("mrst_dout", 32'(mem_dout), 32'd0);
    chk("mrst_if_data", to_if_data, 32'd0);
    chk("mrst_lsb_data", to_lsb_data, 32'd0);
    chk("mrst_state", 32'(dbg_state), 32'd0);
    settle();

    // rdy low for 3 cycles mid-read: ok moves from cycle 6 to 9
    req_if(32'h100);
    repeat (2) tick();
    rdy = 1'b0;
    repeat (2) tick();
    chk("frz_addr", mem_a, 32'h101);
    tick();
    rdy = 1'b1;
    repeat (3) tick();
    chk("frz_early", 32'(to_if_ok), 32'd0);
    tick();
    chk("frz_ok", 32'(to_if_ok), 32'd1);
    chk("frz_data", to_if_data, 32'h0000_0513);
    if_ready = 1'b0;
    settle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (if_ready && to_if_ok) if_ready = 1'b0;
      else if (!if_ready && $urandom_range(0, 3) == 0) req_if(rand_addr());
      if (lsb_ready && to_lsb_ok) lsb_ready = 1'b0;
      else if (!lsb_ready && $urandom_range(0, 3) == 0)
        req_lsb(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), rand_addr(), $urandom);
      rdy       = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) io_buffer_full = ~io_buffer_full;
    end

    // drain outstanding requests
    rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
    pend = 1;
    for (int c = 0; c < 200 && pend != 0; c++) begin
      tick();
      if (if_ready && to_if_ok) if_ready = 1'b0;
      if (lsb_ready && to_lsb_ok) lsb_ready = 1'b0;
      pend = (if_ready || lsb_ready) ? 1 : 0;
    end
    chk("drain_pending", 32'(pend), 32'd0);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the 8-bit RAM/IO port and the two 32-bit requesters: the instruction fetcher (word reads) and the load/store buffer (byte, half and word reads and writes). It arbitrates between the two requesters and sequences one byte per cycle over the RAM port. It returns little-endian assembled data with a one-cycle `ok` pulse. It also handles ROB rollback and IO back-pressure.

## Interface
- Parameters: none.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, every register holds.
- mem_din  in  8  RAM read byte, valid the cycle after its address.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- io_buffer_full  in  1  UART buffer full.
- if_ready  in  1  fetch request; held until `to_if_ok`.
- if_addr  in  32  fetch word address.
- to_if_ok  out  1  one-cycle pulse; `to_if_data` is valid in that cycle.
- to_if_data  out  32  fetched instruction.
- lsb_ready  in  1  load/store request; held until `to_lsb_ok`.
- lsb_wr  in  1  1 = store.
- lsb_len  in  2  0 = byte, 1 = half, 2 = word (3 is illegal).
- lsb_addr  in  32  start byte address.
- lsb_wdata  in  32  store data; the low bytes are used.
- to_lsb_ok  out  1  one-cycle pulse.
- to_lsb_data  out  32  load data, zero-extended.
- rob_clear  in  1  misprediction rollback.

## Operation
- States: IDLE, READ, WRITE, DONE. The controller records the owner of each transaction (IF or LSB).
- IDLE arbitration:
  - LSB has priority over IF.
  - An LSB store with `lsb_addr[17:16]==2'b11` is blocked while `io_buffer_full` is high. While it is blocked, an IF request may be served.
  - On accept, latch the owner, address, n = 1/2/4 bytes (IF is always 4), the write data, and cnt = 0.
  - A read goes to READ; a write goes to WRITE.
- READ:
  - Drive `mem_a` = base+i with `mem_wr`=0 for i = 0..n-1.
  - Byte i arrives on `mem_din` one cycle after its address. It lands in result bits [8i+7:8i].
  - After the last byte is captured: raise the owner's `ok`, register the data, go to DONE.
- WRITE:
  - Drive `mem_a` = base+i, `mem_dout` = wdata[8i+7:8i], `mem_wr`=1 for i = 0..n-1.
  - After the last byte: `mem_wr`=0, raise `to_lsb_ok`, go to DONE.
- DONE:
  - Lasts one cycle. The `ok` pulse is visible during this cycle, and the requester drops `ready` at its end.
  - Then `ok`=0 and the state returns to IDLE. A request cannot be accepted in DONE, so the same request is never re-accepted.
- Data widths: unused upper bytes of `to_lsb_data` are 0. Sign extension is done by the LSB. Addresses increment mod 2^32.
- rob_clear:
  - In READ (either owner) or IDLE: abort. Go to IDLE with `mem_wr`=0, no `ok` pulse, and discard partial data.
  - In WRITE: ignored. A committed store completes and pulses `ok`.
  - In DONE: the `ok` pulse still occurs.
  - `rob_clear` has priority over a new accept in the same cycle.
- rdy low: all state freezes. `mem_wr` holds, so a frozen write repeats the same byte, which is harmless.
- Reset values: state IDLE, `mem_a`=0, `mem_dout`=0, `mem_wr`=0, both `ok` outputs 0, both data outputs 0.

## Timing
- Cycle 0: IDLE samples the request.
- Reads:
  - Byte i address is on `mem_a` in cycle 1+i; its data is on `mem_din` in cycle 2+i.
  - `ok` is high in cycle n+2: word at cycle 6, half at 4, byte at 3.
- Writes: byte i is written in cycle 1+i; `ok` is high in cycle n+1 (word at 5).
- The next request can be accepted at the earliest in cycle ok+1.
- Back-to-back word fetches take 7 cycles each.
- `ok` is exactly one cycle wide.

## Test plan
- Word fetch: RAM[0x100..0x103]=13,05,00,00; if_ready, if_addr=0x100 → `mem_a` 0x100..0x103 in cycles 1–4; `to_if_ok` only in cycle 6 with data 0x00000513.
- Arbitration: if_ready and lsb_ready (load byte at 0x7) raised together → LSB served first; `to_lsb_data`=0x000000XX; IF `ok` follows 7+ cycles later.
- Half store 0xBEEF to 0x200 → cycles 1–2 write EF@0x200 then BE@0x201 with `mem_wr`=1; `to_lsb_ok` in cycle 3; `mem_wr`=0 afterwards.
- IO stall: io_buffer_full=1 and word store to 0x30000 → no `mem_wr` while full; a pending IF request is served meanwhile; the store starts once io_buffer_full falls.
- Rollback: `rob_clear` in cycle 3 of a word fetch → IDLE next cycle, no `to_if_ok`, `mem_wr`=0. `rob_clear` in cycle 2 of a word store → all 4 bytes are written and `ok` pulses.
- `rst` mid-read, and `rdy` low for 3 cycles mid-read → reset returns all outputs to 0 and IDLE; the `rdy` freeze extends latency by exactly 3 cycles with correct data.
